// File: rtl/ibex_ex_issue_ctrl.sv
// Issue/writeback sequencer between decoder and EX: drives EX enables/selects, owns imd registers.
// Latency: accept -> EXEC next cycle; EX completion -> registered wb_valid_o next cycle.
// Backpressure: holds the result in WB until wb_ready_i; kill_i overrides everything and returns to IDLE.
module ibex_ex_issue_ctrl #(
    // Encoding follows ibex_pkg::rv32m_e: 0 None, 1 Slow, 2 Fast, 3 SingleCycle.
    parameter int unsigned RV32M = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [1:0]  op_class_i,
    input  logic        kill_i,
    output logic        mult_en_o,
    output logic        div_en_o,
    output logic        mult_sel_o,
    output logic        div_sel_o,
    output logic        alu_instr_first_cycle_o,
    output logic        multdiv_ready_id_o,
    input  logic [1:0]  imd_val_we_i,
    input  logic [33:0] imd_val_d_i [2],
    output logic [33:0] imd_val_q_o [2],
    input  logic        ex_valid_i,
    input  logic [31:0] result_ex_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [31:0] wb_result_o,
    output logic        ex_stall_o
);

    localparam int unsigned RV32MNone = 0;
    localparam logic [1:0]  CLS_ALU   = 2'b00;
    localparam logic [1:0]  CLS_MUL   = 2'b01;
    localparam logic [1:0]  CLS_DIV   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cls_q, cls_in;
    logic        first_q;
    logic [31:0] wb_result_q;
    logic        in_idle, in_exec, in_wb;
    logic        accept;
    logic        capture;

    assign in_idle = (state_q == IDLE);
    assign in_exec = (state_q == EXEC);
    assign in_wb   = (state_q == WB);

    assign instr_ready_o = ~kill_i & (in_idle | (in_wb & wb_ready_i));
    assign accept        = instr_valid_i & instr_ready_o;
    assign capture       = in_exec & ex_valid_i & ~kill_i;

    // Class is normalised at capture so every downstream decode sees only ALU/MUL/DIV.
    always_comb begin
        cls_in = op_class_i;
        if (op_class_i == 2'b11 || RV32M == RV32MNone) begin
            cls_in = CLS_ALU;
        end
    end

    assign mult_sel_o              = in_exec & (cls_q == CLS_MUL);
    assign div_sel_o               = in_exec & (cls_q == CLS_DIV);
    assign mult_en_o               = mult_sel_o & ~kill_i;
    assign div_en_o                = div_sel_o & ~kill_i;
    assign alu_instr_first_cycle_o = in_exec & first_q;
    assign multdiv_ready_id_o      = in_exec;
    assign ex_stall_o              = in_exec & ~ex_valid_i;
    assign wb_valid_o              = in_wb & ~kill_i;
    assign wb_result_o             = wb_result_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: if (ex_valid_i) state_d = WB;
            WB:   if (wb_ready_i) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cls_q       <= CLS_ALU;
            first_q     <= 1'b0;
            wb_result_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cls_q   <= cls_in;
                first_q <= 1'b1;
            end else if (in_exec) begin
                first_q <= 1'b0;
            end
            if (capture) begin
                wb_result_q <= result_ex_i;
            end
        end
    end

    // Intermediate values persist across instructions; only EX writes during EXEC land.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 2; k++) begin
                imd_val_q_o[k] <= 34'h0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (imd_val_we_i[k] && in_exec && !kill_i) begin
                    imd_val_q_o[k] <= imd_val_d_i[k];
                end
            end
        end
    end

endmodule
